// File: rtl/line_buffer_pkg.sv
// line_buffer_pkg: shared types and constants for the line-buffer sequencing stages
package line_buffer_pkg;
  localparam int LBS_COORD_BITS = 12;
  localparam int LBS_MIN_DIM = 1;
  typedef logic [LBS_COORD_BITS-1:0] coord_t;
  typedef enum logic [1:0] {IDLE, PREP, RUN, DRAIN} lbs_state_t;
endpackage

// File: rtl/raster_counter.sv
// raster_counter: x/y raster position counter wrapping at width/height, flags the final pixel
module raster_counter #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         advance,
  input  logic [W-1:0] width,
  input  logic [W-1:0] height,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         last
);
  logic x_end, y_end;
  assign x_end = x == width - W'(1);
  assign y_end = y == height - W'(1);
  assign last = x_end && y_end;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      x <= x_end ? '0 : x + W'(1);
      y <= x_end ? (y_end ? '0 : y + W'(1)) : y;
    end
endmodule

// File: rtl/line_buffer_sequencer.sv
// line_buffer_sequencer: gates one raster frame into the multitap shift register and
// emits coordinate/window metadata aligned with the shift register read data
module line_buffer_sequencer import line_buffer_pkg::*; #(
  parameter int COORD_BITS = LBS_COORD_BITS,
  parameter int NUM_TAPS = 3,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_start,
  input  logic [COORD_BITS-1:0] cfg_width,
  input  logic [COORD_BITS-1:0] cfg_height,
  output logic                  cfg_error,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  sr_reset,
  output logic [COORD_BITS-1:0] sr_tap_spacing,
  output logic                  sr_in_valid,
  output logic                  out_valid,
  output logic [COORD_BITS-1:0] out_x,
  output logic [COORD_BITS-1:0] out_y,
  output logic                  out_window_valid,
  output logic                  out_frame_done
);
  localparam int MW = 2 * COORD_BITS + 2;
  localparam int DW = $clog2(READ_LATENCY + 1) + 1;
  localparam logic [COORD_BITS-1:0] MIN_DIM = COORD_BITS'(LBS_MIN_DIM);
  localparam logic [DW-1:0] DRAIN_END = DW'(READ_LATENCY);
  lbs_state_t state, next;
  logic [COORD_BITS-1:0] width_q, height_q, tap_q, x, y;
  logic [DW-1:0] dcnt;
  logic last, accept, start_ok, launch;
  logic [MW-1:0] pipe [READ_LATENCY];
  assign start_ok = cfg_width >= MIN_DIM && cfg_height >= MIN_DIM;
  assign launch = state == IDLE && cfg_start && start_ok;
  assign accept = in_valid && in_ready;
  assign sr_in_valid = accept;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = launch ? PREP : IDLE;
      PREP:    next = RUN;
      RUN:     next = accept && last ? DRAIN : RUN;
      default: next = dcnt == DRAIN_END ? IDLE : DRAIN;
    endcase
  end
  always_comb begin
    in_ready = state == RUN;
    busy = state != IDLE;
    sr_reset = reset || state == PREP;
    cfg_error = state == IDLE && cfg_start && !start_ok;
    out_frame_done = state == DRAIN && dcnt == DRAIN_END;
    sr_tap_spacing = state == PREP ? width_q - COORD_BITS'(1) : tap_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      width_q <= '0;
      height_q <= '0;
      tap_q <= '0;
      dcnt <= '0;
    end else begin
      if (launch) begin
        width_q <= cfg_width;
        height_q <= cfg_height;
      end
      if (state == PREP) tap_q <= width_q - COORD_BITS'(1);
      dcnt <= state == DRAIN ? dcnt + DW'(1) : '0;
    end
  raster_counter #(.W(COORD_BITS)) u_raster (
    .clk(clk),
    .reset(reset),
    .clear(state == PREP),
    .advance(accept),
    .width(width_q),
    .height(height_q),
    .x(x),
    .y(y),
    .last(last)
  );
  // Metadata rides alongside the shift register so it lands with the tap data.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
    end else if (state == PREP) begin
      for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {accept, y >= COORD_BITS'(NUM_TAPS), x, y};
      for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  assign {out_valid, out_window_valid, out_x, out_y} = pipe[READ_LATENCY-1];
endmodule

// File: tb/tb_line_buffer_sequencer.sv
// tb_line_buffer_sequencer: table-driven frame check plus directed stall, 1x1 and reset sequences
module tb_line_buffer_sequencer;
  typedef struct {
    logic st;
    logic [11:0] w, h;
    logic v, rdy, srr, bsy, err, ov;
    logic [11:0] ox, oy;
    logic wv, fd;
    logic [11:0] tap;
  } vec_t;
  logic clk = 0, reset = 1, cfg_start = 0, in_valid = 0;
  logic [11:0] cfg_width = 0, cfg_height = 0;
  logic cfg_error, busy, in_ready, sr_reset, sr_in_valid, out_valid, out_window_valid, out_frame_done;
  logic [11:0] sr_tap_spacing, out_x, out_y;
  logic b_cfg_error, b_busy, b_in_ready, b_sr_reset, b_sr_in_valid, b_out_valid, b_out_window_valid, b_out_frame_done;
  logic [11:0] b_sr_tap_spacing, b_out_x, b_out_y;
  int checks = 0, errors = 0;
  int nacc, nov, nfd, idx;
  logic stalled;
  vec_t tbl[$];
  always #5 clk = ~clk;
  line_buffer_sequencer #(.COORD_BITS(12), .NUM_TAPS(3), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_error(cfg_error), .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .sr_reset(sr_reset),
    .sr_tap_spacing(sr_tap_spacing), .sr_in_valid(sr_in_valid), .out_valid(out_valid), .out_x(out_x),
    .out_y(out_y), .out_window_valid(out_window_valid), .out_frame_done(out_frame_done)
  );
  line_buffer_sequencer #(.COORD_BITS(12), .NUM_TAPS(2), .READ_LATENCY(1)) dut2 (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_error(b_cfg_error), .busy(b_busy), .in_valid(in_valid), .in_ready(b_in_ready), .sr_reset(b_sr_reset),
    .sr_tap_spacing(b_sr_tap_spacing), .sr_in_valid(b_sr_in_valid), .out_valid(b_out_valid), .out_x(b_out_x),
    .out_y(b_out_y), .out_window_valid(b_out_window_valid), .out_frame_done(b_out_frame_done)
  );
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  function automatic vec_t mk(logic st, int w, int h, logic v, logic rdy, logic srr, logic bsy, logic err,
                              logic ov, int ox, int oy, logic wv, logic fd, int tap);
    vec_t r;
    r.st = st; r.w = 12'(w); r.h = 12'(h); r.v = v; r.rdy = rdy; r.srr = srr; r.bsy = bsy; r.err = err;
    r.ov = ov; r.ox = 12'(ox); r.oy = 12'(oy); r.wv = wv; r.fd = fd; r.tap = 12'(tap);
    return r;
  endfunction
  initial begin
    tbl.push_back(mk(1, 4, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4, 3, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 4, 3, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 3));
    for (int k = 1; k < 12; k++)
      tbl.push_back(mk(0, 4, 3, 1, 1, 0, 1, 0, 1, (k - 1) % 4, (k - 1) / 4, (k - 1) >= 8, 0, 3));
    tbl.push_back(mk(0, 4, 3, 1, 0, 0, 1, 0, 1, 3, 2, 1, 0, 3));
    tbl.push_back(mk(0, 4, 3, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 3));
    tbl.push_back(mk(0, 4, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(1, 0, 7, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sr_reset", sr_reset, 1);
    chk("rst_tap", sr_tap_spacing, 0);
    chk("rst_err", cfg_error, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_x", out_x, 0);
    chk("rst_y", out_y, 0);
    chk("rst_wv", out_window_valid, 0);
    chk("rst_fd", out_frame_done, 0);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("sr_reset_drop", sr_reset, 0);
    foreach (tbl[i]) begin
      @(posedge clk); #1;
      cfg_start = tbl[i].st; cfg_width = tbl[i].w; cfg_height = tbl[i].h; in_valid = tbl[i].v;
      @(negedge clk);
      chk($sformatf("r%0d_ready", i), in_ready, tbl[i].rdy);
      chk($sformatf("r%0d_sr_reset", i), sr_reset, tbl[i].srr);
      chk($sformatf("r%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("r%0d_err", i), cfg_error, tbl[i].err);
      chk($sformatf("r%0d_fd", i), out_frame_done, tbl[i].fd);
      chk($sformatf("r%0d_tap", i), sr_tap_spacing, tbl[i].tap);
      chk($sformatf("r%0d_sr_in_valid", i), sr_in_valid, tbl[i].rdy & tbl[i].v);
      chk($sformatf("r%0d_ov", i), out_valid, tbl[i].ov);
      chk($sformatf("r%0d_ov2", i), b_out_valid, tbl[i].ov);
      if (tbl[i].ov) begin
        chk($sformatf("r%0d_x", i), out_x, tbl[i].ox);
        chk($sformatf("r%0d_y", i), out_y, tbl[i].oy);
        chk($sformatf("r%0d_wv3", i), out_window_valid, tbl[i].oy >= 3);
        chk($sformatf("r%0d_wv2", i), b_out_window_valid, tbl[i].wv);
      end
    end
    // 5x2 frame with random stalls, a forced stall on the last pixel and a start during RUN
    @(posedge clk); #1 cfg_start = 1; cfg_width = 5; cfg_height = 2; in_valid = 0;
    nacc = 0; nfd = 0; idx = 0; stalled = 0;
    for (int c = 0; c < 300 && nfd == 0; c++) begin
      @(negedge clk);
      if (sr_in_valid) nacc++;
      if (out_valid) begin
        chk("stall_x", out_x, idx % 5);
        chk("stall_y", out_y, idx / 5);
        idx++;
      end
      if (out_frame_done) nfd++;
      if (c == 4) begin
        chk("busy_start_err", cfg_error, 0);
        chk("busy_start_busy", busy, 1);
      end
      @(posedge clk); #1;
      cfg_start = c == 3;
      cfg_width = c == 3 ? 12'd0 : 12'd5;
      cfg_height = c == 3 ? 12'd0 : 12'd2;
      if (nacc == 9 && !stalled) begin
        in_valid = 0;
        stalled = 1;
      end else in_valid = 1'($urandom_range(0, 1));
    end
    chk("stall_fd", nfd, 1);
    chk("stall_accepts", nacc, 10);
    chk("stall_outs", idx, 10);
    chk("stall_last_stalled", stalled, 1);
    in_valid = 0;
    @(negedge clk);
    chk("stall_idle", busy, 0);
    chk("stall_tap_held", sr_tap_spacing, 4);
    // 1x1 frame
    @(posedge clk); #1 cfg_start = 1; cfg_width = 1; cfg_height = 1; in_valid = 1;
    nacc = 0; nov = 0; nfd = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 1) chk("one_tap", sr_tap_spacing, 0);
      if (sr_in_valid) nacc++;
      if (out_frame_done) nfd++;
      if (out_valid) begin
        nov++;
        chk("one_x", out_x, 0);
        chk("one_y", out_y, 0);
      end
      @(posedge clk); #1 cfg_start = 0;
    end
    chk("one_accepts", nacc, 1);
    chk("one_outs", nov, 1);
    chk("one_fd", nfd, 1);
    @(negedge clk);
    chk("one_idle", busy, 0);
    // reset while pixel (2,1) of a 4x3 frame is accepted
    in_valid = 1; cfg_width = 4; cfg_height = 3; nacc = 0;
    for (int c = 0; c < 60 && nacc < 7; c++) begin
      @(posedge clk); #1 cfg_start = c == 0;
      @(negedge clk);
      if (sr_in_valid) nacc++;
    end
    chk("mid_accepts", nacc, 7);
    chk("mid_pre_ov", out_valid, 1);
    chk("mid_pre_x", out_x, 1);
    chk("mid_pre_y", out_y, 1);
    #1 reset = 1;
    #1;
    chk("mid_ready", in_ready, 0);
    chk("mid_ov", out_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_sr_reset", sr_reset, 1);
    @(posedge clk); #1 reset = 0; cfg_width = 3; cfg_height = 2;
    nov = 0;
    for (int c = 0; c < 30 && nov < 2; c++) begin
      @(posedge clk); #1 cfg_start = c == 0;
      @(negedge clk);
      if (out_valid) begin
        chk("restart_x", out_x, nov);
        chk("restart_y", out_y, 0);
        nov++;
      end
    end
    chk("restart_outs", nov, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
